// File: rtl/register_file_pkg.sv
// Shared register-file types: architectural depth, default data width,
// controller state encoding and the register address type.
package register_file_pkg;

  localparam int REGISTER_DEPTH = 32;
  localparam int REGISTER_WIDTH = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_t;

  typedef logic [$clog2(REGISTER_DEPTH)-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: enable/ready gating, x0 reads as zero,
// same-cycle write bypass, otherwise the stored entry.
module register_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH = REGISTER_WIDTH,
  parameter int DEPTH = REGISTER_DEPTH
) (
  input  logic                            enable,
  input  logic [$clog2(DEPTH)-1:0]        address,
  input  logic                            ready,
  input  logic                            write_enable,
  input  logic [$clog2(DEPTH)-1:0]        write_address,
  input  logic [WIDTH-1:0]                write_data,
  input  logic [DEPTH-1:0][WIDTH-1:0]     mem,
  output logic [WIDTH-1:0]                data
);

  localparam int AW = $clog2(DEPTH);

  // Priority select of the returned read data
  always_comb begin
    data = {WIDTH{1'b0}};
    if (!enable) begin
      data = {WIDTH{1'b0}};
    end else if (!ready) begin
      data = {WIDTH{1'b0}};
    end else if (address == {AW{1'b0}}) begin
      data = {WIDTH{1'b0}};
    end else if (write_enable && (write_address == address)) begin
      data = write_data;
    end else begin
      data = mem[address];
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: two combinational read ports with write bypass,
// one synchronous write port, and a post-reset clear of every entry.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = REGISTER_WIDTH,
  parameter int DEPTH = REGISTER_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     registerport_read_1_enable,
  input  logic [$clog2(DEPTH)-1:0] registerport_read_1_address,
  output logic [WIDTH-1:0]         registerport_read_1_data,
  input  logic                     registerport_read_2_enable,
  input  logic [$clog2(DEPTH)-1:0] registerport_read_2_address,
  output logic [WIDTH-1:0]         registerport_read_2_data,
  input  logic                     registerport_write_enable,
  input  logic [$clog2(DEPTH)-1:0] registerport_write_address,
  input  logic [WIDTH-1:0]         registerport_write_data,
  output logic                     ready,
  output logic                     write_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

  regfile_state_t              state_r;
  regfile_state_t              state_next_s;
  logic [AW-1:0]               clear_index_r;
  logic                        ready_r;
  logic                        write_dropped_r;
  logic [DEPTH-1:0][WIDTH-1:0] mem_r;
  logic                        mem_we_s;
  logic [AW-1:0]               mem_waddr_s;
  logic [WIDTH-1:0]            mem_wdata_s;
  logic                        write_drop_s;

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: leave CLEAR once the last entry is being zeroed
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clear_index_r == LAST_INDEX) begin
          state_next_s = READY;
        end else begin
          state_next_s = CLEAR;
        end
      end
      READY:   state_next_s = READY;
      default: state_next_s = CLEAR;
    endcase
  end

  // Storage write controls: the clear sequencer owns the array until READY
  always_comb begin
    mem_we_s     = 1'b0;
    mem_waddr_s  = clear_index_r;
    mem_wdata_s  = {WIDTH{1'b0}};
    write_drop_s = 1'b0;
    case (state_r)
      CLEAR: begin
        mem_we_s     = 1'b1;
        mem_waddr_s  = clear_index_r;
        mem_wdata_s  = {WIDTH{1'b0}};
        write_drop_s = registerport_write_enable;
      end
      READY: begin
        mem_we_s     = registerport_write_enable &&
                       (registerport_write_address != {AW{1'b0}});
        mem_waddr_s  = registerport_write_address;
        mem_wdata_s  = registerport_write_data;
        write_drop_s = 1'b0;
      end
      default: begin
        mem_we_s     = 1'b0;
        mem_waddr_s  = clear_index_r;
        mem_wdata_s  = {WIDTH{1'b0}};
        write_drop_s = 1'b0;
      end
    endcase
  end

  // Clear index: advances through the array while clearing, holds at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_index_r <= {AW{1'b0}};
    end else if ((state_r == CLEAR) && (clear_index_r != LAST_INDEX)) begin
      clear_index_r <= clear_index_r + AW'(1);
    end else begin
      clear_index_r <= clear_index_r;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r         <= 1'b0;
      write_dropped_r <= 1'b0;
    end else begin
      ready_r         <= (state_next_s == READY);
      write_dropped_r <= write_drop_s;
    end
  end

  // Register array; not reset directly because CLEAR zeroes it
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign ready         = ready_r;
  assign write_dropped = write_dropped_r;

  register_read_port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_read_port_1 (
    .enable       (registerport_read_1_enable),
    .address      (registerport_read_1_address),
    .ready        (ready_r),
    .write_enable (registerport_write_enable),
    .write_address(registerport_write_address),
    .write_data   (registerport_write_data),
    .mem          (mem_r),
    .data         (registerport_read_1_data)
  );

  register_read_port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_read_port_2 (
    .enable       (registerport_read_2_enable),
    .address      (registerport_read_2_address),
    .ready        (ready_r),
    .write_enable (registerport_write_enable),
    .write_address(registerport_write_address),
    .write_data   (registerport_write_data),
    .mem          (mem_r),
    .data         (registerport_read_2_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random
// traffic compared against a behavioural register-file model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        r1_en, r2_en, w_en;
  logic [4:0]  r1_addr, r2_addr, w_addr;
  logic [31:0] r1_data, r2_data, w_data;
  logic        ready, write_dropped;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [32];
  bit          model_ready;
  int          model_clear_cnt;
  bit          model_dropped;

  always #5 clk = ~clk;

  register_file dut (
    .clk                        (clk),
    .rst                        (rst),
    .registerport_read_1_enable (r1_en),
    .registerport_read_1_address(r1_addr),
    .registerport_read_1_data   (r1_data),
    .registerport_read_2_enable (r2_en),
    .registerport_read_2_address(r2_addr),
    .registerport_read_2_data   (r2_data),
    .registerport_write_enable  (w_en),
    .registerport_write_address (w_addr),
    .registerport_write_data    (w_data),
    .ready                      (ready),
    .write_dropped              (write_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (!en || !model_ready || a == 5'd0) return 32'd0;
    if (w_en && w_addr == a) return w_data;
    return model_mem[a];
  endfunction

  // One clock: check reads mid-cycle, advance the model at the edge, check status
  task automatic cycle();
    #2;
    chk("rd1", r1_data, model_read(r1_en, r1_addr));
    chk("rd2", r2_data, model_read(r2_en, r2_addr));
    @(posedge clk);
    if (rst) begin
      model_ready     = 1'b0;
      model_clear_cnt = 0;
      model_dropped   = 1'b0;
    end else begin
      model_dropped = w_en && !model_ready;
      if (model_ready) begin
        if (w_en && w_addr != 5'd0) model_mem[w_addr] = w_data;
      end else begin
        model_clear_cnt++;
        if (model_clear_cnt == 32) begin
          model_ready = 1'b1;
          for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        end
      end
    end
    #1;
    chk("ready", {31'd0, ready}, {31'd0, model_ready});
    chk("wdrop", {31'd0, write_dropped}, {31'd0, model_dropped});
  endtask

  initial begin
    rst = 1'b1;
    r1_en = 1'b0; r2_en = 1'b0; w_en = 1'b0;
    r1_addr = 5'd0; r2_addr = 5'd0; w_addr = 5'd0;
    w_data = 32'd0;
    model_ready = 1'b0; model_clear_cnt = 0; model_dropped = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
    @(posedge clk);
    #1;

    // Clear sequence with a write arriving during CLEAR
    repeat (3) cycle();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    r1_en = 1'b1; r1_addr = 5'd5;
    for (int c = 0; c < 32; c++) begin
      if (c == 4) begin
        w_en = 1'b1; w_addr = 5'd4; w_data = 32'hAAAA5555;
      end else begin
        w_en = 1'b0;
      end
      chk("clear_not_ready", {31'd0, ready}, 32'd0);
      chk("clear_x5", r1_data, 32'd0);
      cycle();
      if (c == 4) chk("drop_pulse", {31'd0, write_dropped}, 32'd1);
      if (c == 5) chk("drop_once", {31'd0, write_dropped}, 32'd0);
    end
    chk("ready_after_32", {31'd0, ready}, 32'd1);
    w_en = 1'b0;
    r2_en = 1'b1; r2_addr = 5'd4;
    #1;
    chk("x5_after_ready", r1_data, 32'd0);
    chk("x4_dropped_reads0", r2_data, 32'd0);
    cycle();

    // Write then read on both ports
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'hDEADBEEF;
    r1_en = 1'b0; r2_en = 1'b0;
    cycle();
    w_en = 1'b0;
    r1_en = 1'b1; r1_addr = 5'd3; r2_en = 1'b1; r2_addr = 5'd3;
    #1;
    chk("x3_port1", r1_data, 32'hDEADBEEF);
    chk("x3_port2", r2_data, 32'hDEADBEEF);
    cycle();

    // Same-cycle bypass
    w_en = 1'b1; w_addr = 5'd7; w_data = 32'h12345678;
    r1_addr = 5'd7; r2_addr = 5'd7;
    #1;
    chk("bypass_p1", r1_data, 32'h12345678);
    chk("bypass_p2", r2_data, 32'h12345678);
    cycle();
    w_en = 1'b0;
    #1;
    chk("x7_stored", r1_data, 32'h12345678);
    cycle();

    // x0 protection
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF;
    r1_addr = 5'd0; r2_addr = 5'd0;
    #1;
    chk("x0_same_p1", r1_data, 32'd0);
    chk("x0_same_p2", r2_data, 32'd0);
    cycle();
    chk("x0_no_drop", {31'd0, write_dropped}, 32'd0);
    w_en = 1'b0;
    #1;
    chk("x0_next", r1_data, 32'd0);
    cycle();

    // Fill, reset mid-operation, full re-clear
    for (int i = 1; i < 32; i++) begin
      w_en = 1'b1; w_addr = 5'(i); w_data = 32'(i);
      cycle();
    end
    w_en = 1'b0;
    r1_addr = 5'd9; r2_addr = 5'd31;
    #1;
    chk("fill_x9", r1_data, 32'd9);
    rst = 1'b1;
    cycle();
    chk("rst_drops_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    repeat (32) cycle();
    chk("reclear_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      r1_addr = 5'(i); r2_addr = 5'(31 - i);
      #1;
      chk("reclear_zero", r1_data, 32'd0);
      cycle();
    end
    r1_en = 1'b0; r2_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; w_addr = 5'($urandom_range(1, 31)); w_data = $urandom;
      r1_addr = w_addr; r2_addr = 5'($urandom_range(0, 31));
      #1;
      chk("disabled_read", r1_data, 32'd0);
      cycle();
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      w_en    = ($urandom_range(0, 1) == 1);
      w_addr  = 5'($urandom_range(0, 31));
      w_data  = $urandom;
      r1_en   = ($urandom_range(0, 3) != 0);
      r2_en   = ($urandom_range(0, 3) != 0);
      r1_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom_range(0, 31));
      r2_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
